// File: rtl/intr_ctl.sv
// Interrupt/exception sequencer: edge-latched requests, software mask, fixed-priority
// arbitration against the decoder exception flag, one-cycle take strobe and EPC/cause capture.
module intr_ctl #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0180,
    localparam int unsigned IdW        = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               exc,
    input  logic [31:0]        pc,
    input  logic               instr_valid,
    input  logic               eret,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               irq,
    output logic [31:0]        vector,
    output logic [31:0]        epc,
    output logic [4:0]         cause,
    output logic [IdW-1:0]     irq_id,
    output logic               in_service,
    output logic               double_fault,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StTake    = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    localparam logic [4:0] CauseInt = 5'd0;
    localparam logic [4:0] CauseRi  = 5'd10;

    logic [1:0]         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_in_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               irq_q, irq_d;
    logic [31:0]        epc_q, epc_d;
    logic [4:0]         cause_q, cause_d;
    logic [IdW-1:0]     irq_id_q, irq_id_d;
    logic               in_service_q, in_service_d;
    logic               double_fault_q, double_fault_d;

    logic [NUM_IRQ-1:0] rise, req, clr;
    logic [IdW-1:0]     low_idx;

    assign rise = irq_in & ~irq_in_q;
    assign req  = pending_q & mask_q;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) low_idx = IdW'(i);
        end
    end

    always_comb begin
        state_d        = state_q;
        irq_d          = 1'b0;
        epc_d          = epc_q;
        cause_d        = cause_q;
        irq_id_d       = irq_id_q;
        in_service_d   = in_service_q;
        double_fault_d = double_fault_q;
        clr            = '0;
        case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    if (exc) begin
                        state_d = StTake;
                        irq_d   = 1'b1;
                        cause_d = CauseRi;
                        epc_d   = pc;
                    end else if (|req) begin
                        state_d  = StTake;
                        irq_d    = 1'b1;
                        cause_d  = CauseInt;
                        epc_d    = pc;
                        irq_id_d = low_idx;
                        clr      = NUM_IRQ'(1) << low_idx;
                    end
                end
            end
            StTake: begin
                state_d      = StService;
                in_service_d = 1'b1;
            end
            StService: begin
                if (instr_valid && eret) begin
                    state_d      = StIdle;
                    in_service_d = 1'b0;
                end else if (instr_valid && exc) begin
                    double_fault_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new rise beats a same-cycle clear.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            irq_in_q       <= '0;
            pending_q      <= '0;
            mask_q         <= '0;
            irq_q          <= 1'b0;
            epc_q          <= '0;
            cause_q        <= '0;
            irq_id_q       <= '0;
            in_service_q   <= 1'b0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            irq_in_q       <= irq_in;
            pending_q      <= pending_d;
            mask_q         <= mask_d;
            irq_q          <= irq_d;
            epc_q          <= epc_d;
            cause_q        <= cause_d;
            irq_id_q       <= irq_id_d;
            in_service_q   <= in_service_d;
            double_fault_q <= double_fault_d;
        end
    end

    assign irq          = irq_q;
    assign vector       = (state_q == StTake) ? VECTOR_BASE : 32'h0;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign irq_id       = irq_id_q;
    assign in_service   = in_service_q;
    assign double_fault = double_fault_q;
    assign pending      = pending_q;
    assign mask         = mask_q;

endmodule

// File: tb/tb_intr_ctl.sv
// Bench for intr_ctl: directed scenarios then random traffic, every cycle checked against
// a behavioural model of the take/service/return protocol.
module tb_intr_ctl;

    localparam int unsigned N    = 8;
    localparam logic [31:0] BASE = 32'h0000_0180;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         exc, instr_valid, eret, mask_we;
    logic [31:0]  pc;
    logic [N-1:0] mask_wdata;
    logic         irq, in_service, double_fault;
    logic [31:0]  vector, epc;
    logic [4:0]   cause;
    logic [2:0]   irq_id;
    logic [N-1:0] pending, mask;

    intr_ctl #(.NUM_IRQ(N), .VECTOR_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .exc(exc), .pc(pc),
        .instr_valid(instr_valid), .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .irq(irq), .vector(vector), .epc(epc), .cause(cause), .irq_id(irq_id),
        .in_service(in_service), .double_fault(double_fault), .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: "taking" = strobe cycle, "serving" = handler running; neither = idle.
    bit           m_taking, m_serving, m_df;
    bit [N-1:0]   m_prev, m_pend, m_mask;
    bit [31:0]    m_epc;
    int           m_cause, m_id;

    task automatic model_step();
        bit [N-1:0] rise;
        bit [N-1:0] clr;
        if (reset) begin
            m_taking = 0; m_serving = 0; m_df = 0; m_prev = '0; m_pend = '0;
            m_mask = '0; m_epc = 0; m_cause = 0; m_id = 0;
            return;
        end
        rise = irq_in & ~m_prev;
        clr  = '0;
        if (m_taking) begin
            m_taking  = 0;
            m_serving = 1;
        end else if (m_serving) begin
            if (instr_valid && eret) m_serving = 0;
            else if (instr_valid && exc) m_df = 1;
        end else if (instr_valid) begin
            if (exc) begin
                m_taking = 1; m_cause = 10; m_epc = pc;
            end else if ((m_pend & m_mask) != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && m_mask[i]) begin
                        m_id = i;
                        break;
                    end
                end
                m_taking = 1; m_cause = 0; m_epc = pc;
                clr[m_id] = 1'b1;
            end
        end
        m_pend = (m_pend & ~clr) | rise;
        m_prev = irq_in;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic check_all();
        check_eq("irq", 32'(irq), 32'(m_taking));
        check_eq("vector", vector, m_taking ? BASE : 32'h0);
        check_eq("epc", epc, m_epc);
        check_eq("cause", 32'(cause), 32'(m_cause));
        check_eq("irq_id", 32'(irq_id), 32'(m_id));
        check_eq("in_service", 32'(in_service), 32'(m_serving));
        check_eq("double_fault", 32'(double_fault), 32'(m_df));
        check_eq("pending", 32'(pending), 32'(m_pend));
        check_eq("mask", 32'(mask), 32'(m_mask));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        reset = 0; irq_in = '0; exc = 0; instr_valid = 0; eret = 0;
        mask_we = 0; mask_wdata = '0; pc = 32'h0040_0000;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;

        // Single IRQ on line 3.
        mask_we = 1; mask_wdata = 8'hFF; tick(); mask_we = 0;
        irq_in = 8'h08; pc = 32'h0040_0010; instr_valid = 1; tick();
        check_eq("t1_pend3", 32'(pending[3]), 32'd1);
        irq_in = 8'h00; tick();
        check_eq("t1_irq", 32'(irq), 32'd1);
        check_eq("t1_vec", vector, 32'h180);
        check_eq("t1_epc", epc, 32'h0040_0010);
        check_eq("t1_id", 32'(irq_id), 32'd3);
        tick();
        check_eq("t1_irq_low", 32'(irq), 32'd0);
        check_eq("t1_svc", 32'(in_service), 32'd1);
        check_eq("t1_pend3_clr", 32'(pending[3]), 32'd0);
        eret = 1; tick(); eret = 0;

        // Priority: 5 and 1 together.
        irq_in = 8'h22; instr_valid = 0; tick();
        irq_in = 8'h00; instr_valid = 1; tick();
        check_eq("t2_id1", 32'(irq_id), 32'd1);
        check_eq("t2_pend5", 32'(pending[5]), 32'd1);
        tick();
        eret = 1; tick(); eret = 0;
        tick();
        check_eq("t2_id5", 32'(irq_id), 32'd5);
        tick();
        eret = 1; tick(); eret = 0;

        // Exception beats pending line 2; then double fault and eret+exc.
        irq_in = 8'h04; instr_valid = 0; tick();
        irq_in = 8'h00; exc = 1; instr_valid = 1; pc = 32'h0040_0100; tick();
        check_eq("t3_cause", 32'(cause), 32'd10);
        check_eq("t3_pend2", 32'(pending[2]), 32'd1);
        tick();
        pc = 32'h0040_0200; tick();
        check_eq("t3_df", 32'(double_fault), 32'd1);
        check_eq("t3_epc_kept", epc, 32'h0040_0100);
        eret = 1; tick(); eret = 0; exc = 0;
        tick();
        check_eq("t3_id2", 32'(irq_id), 32'd2);
        tick();
        exc = 1; eret = 1; tick(); exc = 0; eret = 0;
        check_eq("t3_df_sticky", 32'(double_fault), 32'd1);

        // Masking.
        mask_we = 1; mask_wdata = 8'h00; instr_valid = 0; tick(); mask_we = 0;
        irq_in = 8'h01; tick(); irq_in = 8'h00;
        instr_valid = 1; tick(); tick();
        check_eq("t4_noirq", 32'(irq), 32'd0);
        mask_we = 1; mask_wdata = 8'h01; tick(); mask_we = 0;
        tick();
        check_eq("t4_take", 32'(irq), 32'd1);

        // Reset during the strobe cycle.
        reset = 1; tick(); reset = 0;
        check_eq("t5_epc0", epc, 32'h0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            irq_in      = irq_in ^ (($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
            exc         = ($urandom_range(0, 9) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            eret        = ($urandom_range(0, 4) == 0);
            mask_we     = ($urandom_range(0, 15) == 0);
            mask_wdata  = N'($urandom);
            pc          = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intr_ctl.md
# intr_ctl

Interrupt and exception sequencer for the single-cycle MIPS core. It latches external interrupt requests, applies a software mask and arbitrates them by fixed priority against the decoder's synchronous `Exception` flag. When it accepts an event it drives the decoder's `irq` strobe for one cycle, captures the EPC and cause, and holds the core in service mode until `eret`.

## Interface
Parameters:
- `NUM_IRQ`, default 8: number of external interrupt lines (2..16).
- `VECTOR_BASE`, default 32'h0000_0180: handler address driven on `vector`.

Ports:
- `clk`, input, 1: core clock; every register updates on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `irq_in`, input, NUM_IRQ: external requests; rising-edge sensitive.
- `exc`, input, 1: decoder `Exception` flag for the current instruction.
- `pc`, input, 32: PC of the current instruction.
- `instr_valid`, input, 1: the current instruction completes this cycle.
- `eret`, input, 1: return-from-exception decoded.
- `mask_we`, input, 1: write enable for the mask register.
- `mask_wdata`, input, NUM_IRQ: new mask value; 1 = line enabled.
- `irq`, output, 1: one-cycle take strobe to the decoder.
- `vector`, output, 32: handler address; equals VECTOR_BASE while `irq` is high, 0 otherwise.
- `epc`, output, 32: captured return PC.
- `cause`, output, 5: 0 = interrupt, 10 = reserved instruction.
- `irq_id`, output, clog2(NUM_IRQ): index of the accepted line.
- `in_service`, output, 1: handler active (EXL bit).
- `double_fault`, output, 1: sticky; set by an exception raised during service.
- `pending`, output, NUM_IRQ: latched requests.
- `mask`, output, NUM_IRQ: current mask.

## Operation
- Edge detect: `irq_in_q` registers `irq_in`; rise = `irq_in & ~irq_in_q`. On a rise, the matching `pending` bit is set at the next edge. A pending bit is cleared only when its line is accepted. If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask: `mask_we` loads `mask_wdata` in any state. Masked lines still latch into `pending`; they are only held off from arbitration.
- FSM states: IDLE, TAKE, SERVICE.
- IDLE: the block decides only when `instr_valid` = 1. Priority order:
  - `exc` = 1: go to TAKE; cause = 10; epc = pc; `irq_id` unchanged.
  - otherwise, `pending & mask` non-zero: go to TAKE; cause = 0; `irq_id` = lowest set index; epc = pc; clear that pending bit.
  - otherwise stay in IDLE.
- IDLE with `instr_valid` = 0: no decision is made; stay in IDLE.
- `eret` in IDLE is ignored.
- TAKE: `irq` = 1 and `vector` = VECTOR_BASE for exactly one cycle, then go unconditionally to SERVICE. `in_service` is set on that same transition.
- SERVICE:
  - new requests only latch into `pending`; no arbitration takes place.
  - `exc` & `instr_valid` sets `double_fault`; epc and cause are not overwritten; the state stays SERVICE.
  - `eret` & `instr_valid` goes to IDLE and clears `in_service`.
  - `eret` and `exc` in the same cycle: `eret` wins and `double_fault` is not set.
- Reset mid-operation, from any state: return to IDLE. All outputs go to 0, including `pending`, `mask` (all lines disabled) and `irq_in_q`. `double_fault` is cleared only by reset.

## Timing
- All outputs are registered except `vector`, which is decoded from the TAKE state.
- Request to pending: `irq_in` rises before edge k, so `pending` is set after edge k.
- Pending to strobe: with the state in IDLE, `instr_valid` = 1 and the line unmasked at edge k+1, the state is TAKE after k+1. `irq` is high during cycle k+1..k+2. `epc`, `cause` and `irq_id` are valid from edge k+1.
- `in_service` rises at edge k+2. A new take is possible no earlier than 1 cycle after the `eret` edge.
- A `mask_we` written at edge n affects arbitration from edge n+1.
- `irq_in` held high produces a single pending set per rising edge; it does not re-trigger.

## Test plan
- Single IRQ: mask = 8'hFF; pulse `irq_in[3]` with pc = 32'h0040_0010 and `instr_valid` = 1. Expect `pending[3]` set after 1 cycle, `irq` high for 1 cycle 2 cycles after the pulse, vector = 32'h180, epc = 32'h0040_0010, cause = 0, irq_id = 3, then `in_service` = 1 and `pending[3]` = 0.
- Priority: raise `irq_in[5]` and `irq_in[1]` together. Expect irq_id = 1 first and `pending[5]` held. After `eret`, expect a second take with irq_id = 5.
- Exception over IRQ: `exc` = 1 with `pending[2]` = 1 in IDLE. Expect cause = 10 and `pending[2]` still 1. After `eret`, expect a take with irq_id = 2.
- Masking: mask = 8'h00 and pulse `irq_in[0]`. Expect `pending[0]` = 1 and no `irq`. Write mask = 8'h01 and expect a take 1 cycle later.
- Double fault: `exc` in SERVICE. Expect `double_fault` = 1 with epc and cause unchanged. Then `eret` and `exc` together in a later SERVICE: expect IDLE and `double_fault` remaining at 1.
- Reset mid-TAKE: assert `reset` during TAKE. Expect `irq`, `in_service`, `pending`, `mask` and `epc` all 0 at the next edge, with the state in IDLE.
